// File: rtl/task_fsm_ctrl.sv
// Start/busy/done job controller with programmable length, abort and pulse/held done.
// Optional job completion counter enabled by defining TASK_FSM_JOB_CNT_EN.
module task_fsm_ctrl #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DONE_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] remain,
  output logic [1:0]       state_o
`ifdef TASK_FSM_JOB_CNT_EN
  ,
  output logic [15:0]      job_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] FINISH = 2'b10;

  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] remain_q, remain_nxt;
  logic             aborted_q, aborted_nxt;
  logic             restart_ok;

  // In held-done mode, ack+start in FINISH launches the next job with no IDLE gap.
  assign restart_ok = (DONE_HOLD != 0) && ack && start;

  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain_q;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != ZERO) begin
            state_nxt  = BUSY;
            remain_nxt = len - ONE;
          end else begin
            state_nxt  = FINISH;
            remain_nxt = ZERO;
          end
        end
      end
      BUSY: begin
        if (abort) begin
          state_nxt   = IDLE;
          remain_nxt  = ZERO;
          aborted_nxt = 1'b1;
        end else if (remain_q == ZERO) begin
          state_nxt = FINISH;
        end else begin
          remain_nxt = remain_q - ONE;
        end
      end
      FINISH: begin
        if (DONE_HOLD == 0) begin
          state_nxt = IDLE;
        end else if (restart_ok) begin
          if (len != ZERO) begin
            state_nxt  = BUSY;
            remain_nxt = len - ONE;
          end else begin
            state_nxt  = FINISH;
            remain_nxt = ZERO;
          end
        end else if (ack) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        remain_nxt = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remain_q  <= ZERO;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      remain_q  <= remain_nxt;
      aborted_q <= aborted_nxt;
    end
  end

  // Outputs decode registers only: no input-to-output combinational path.
  assign busy    = (state == BUSY);
  assign done    = (state == FINISH);
  assign aborted = aborted_q;
  assign remain  = remain_q;
  assign state_o = state;

`ifdef TASK_FSM_JOB_CNT_EN
  logic job_fin;

  // A zero-length restart from FINISH is also a completed job.
  assign job_fin = ((state == BUSY) && !abort && (remain_q == ZERO)) ||
                   ((state == IDLE) && start && (len == ZERO)) ||
                   ((state == FINISH) && restart_ok && (len == ZERO));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      job_cnt <= 16'h0000;
    end else if (job_fin) begin
      job_cnt <= job_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_task_fsm_ctrl.sv
// Directed bench for task_fsm_ctrl: one pulse-done instance and one held-done instance.
module tb_task_fsm_ctrl;

  logic       clk;
  logic       rst;
  logic       start0, abort0, ack0;
  logic [7:0] len0;
  logic       busy0, done0, aborted0;
  logic [7:0] remain0;
  logic [1:0] state0;
  logic       start1, abort1, ack1;
  logic [7:0] len1;
  logic       busy1, done1, aborted1;
  logic [7:0] remain1;
  logic [1:0] state1;
`ifdef TASK_FSM_JOB_CNT_EN
  logic [15:0] jc0, jc1;
`endif

  int checks = 0;
  int errors = 0;

  task_fsm_ctrl #(.CNT_W(8), .DONE_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .len(len0), .abort(abort0), .ack(ack0),
    .busy(busy0), .done(done0), .aborted(aborted0), .remain(remain0), .state_o(state0)
`ifdef TASK_FSM_JOB_CNT_EN
    , .job_cnt(jc0)
`endif
  );

  task_fsm_ctrl #(.CNT_W(8), .DONE_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .len(len1), .abort(abort1), .ack(ack1),
    .busy(busy1), .done(done1), .aborted(aborted1), .remain(remain1), .state_o(state1)
`ifdef TASK_FSM_JOB_CNT_EN
    , .job_cnt(jc1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nbusy;
    bit seen_done;
    rst = 1'b0;
    start0 = 0; abort0 = 0; ack0 = 0; len0 = 0;
    start1 = 0; abort1 = 0; ack1 = 0; len1 = 0;
    #1 rst = 1'b1;
    tick; tick;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_aborted", aborted0, 0);
    chk("rst_remain", remain0, 0);
    chk("rst_state", state0, 0);
    chk("rst_state1", state1, 0);
    rst = 1'b0;
    tick;

    // basic len=5 job
    start0 = 1; len0 = 8'd5;
    tick;
    start0 = 0;
    for (int i = 0; i < 5; i++) begin
      chk("basic_busy", busy0, 1);
      chk("basic_remain", remain0, 32'(4 - i));
      tick;
    end
    chk("basic_done", done0, 1);
    chk("basic_busy_off", busy0, 0);
    chk("basic_state_fin", state0, 2);
    tick;
    chk("basic_done_pulse", done0, 0);
    chk("basic_state_idle", state0, 0);

    // zero length
    start0 = 1; len0 = 8'd0;
    tick;
    start0 = 0;
    chk("zl_state", state0, 2);
    chk("zl_done", done0, 1);
    chk("zl_busy", busy0, 0);
`ifdef TASK_FSM_JOB_CNT_EN
    chk("zl_jobcnt", jc0, 2);
`endif
    tick;
    chk("zl_idle", state0, 0);

    // abort on 3rd busy cycle with a simultaneous start
    start0 = 1; len0 = 8'd10;
    tick;
    start0 = 0;
    tick; tick;
    chk("ab_remain_pre", remain0, 7);
    abort0 = 1; start0 = 1; len0 = 8'd4;
    tick;
    abort0 = 0; start0 = 0;
    chk("ab_state", state0, 0);
    chk("ab_aborted", aborted0, 1);
    chk("ab_remain", remain0, 0);
    chk("ab_done", done0, 0);
    tick;
    chk("ab_pulse", aborted0, 0);
    chk("ab_idle", state0, 0);
    chk("ab_nodone", done0, 0);
`ifdef TASK_FSM_JOB_CNT_EN
    chk("ab_jobcnt", jc0, 2);
`endif

    // abort beats completion
    start0 = 1; len0 = 8'd2;
    tick;
    start0 = 0;
    tick;
    chk("abc_remain0", remain0, 0);
    abort0 = 1;
    tick;
    abort0 = 0;
    chk("abc_state", state0, 0);
    chk("abc_aborted", aborted0, 1);
    chk("abc_done", done0, 0);

    // held done with ignored start, then back-to-back restart
    start1 = 1; len1 = 8'd3;
    tick;
    start1 = 0;
    tick; tick; tick;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start1 = 1; len1 = 8'd7;
      end
      chk("hold_done", done1, 1);
      chk("hold_state", state1, 2);
      tick;
    end
    chk("hold_still", done1, 1);
    ack1 = 1; start1 = 1; len1 = 8'd2;
    tick;
    ack1 = 0; start1 = 0;
    chk("rs_busy", busy1, 1);
    chk("rs_remain", remain1, 1);
    chk("rs_done_off", done1, 0);
    tick;
    chk("rs_busy2", busy1, 1);
    tick;
    chk("rs_done", done1, 1);
    ack1 = 1;
    tick;
    ack1 = 0;
    chk("rs_ack_idle", state1, 0);
    chk("rs_ack_done", done1, 0);
`ifdef TASK_FSM_JOB_CNT_EN
    chk("rs_jobcnt", jc1, 2);
`endif

    // async reset mid-BUSY, between edges
    start0 = 1; len0 = 8'd200;
    tick;
    start0 = 0;
    tick; tick;
    chk("ar_pre_busy", busy0, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy0, 0);
    chk("ar_remain", remain0, 0);
    chk("ar_state", state0, 0);
`ifdef TASK_FSM_JOB_CNT_EN
    chk("ar_jobcnt", jc0, 0);
`endif
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ar_nodone", done0, 0);
      chk("ar_noabort", aborted0, 0);
    end

    // maximum length job
    start0 = 1; len0 = 8'd255;
    tick;
    start0 = 0;
    nbusy = 0;
    seen_done = 0;
    for (int i = 0; i < 300 && !seen_done; i++) begin
      if (busy0) nbusy++;
      if (done0) seen_done = 1;
      else tick;
    end
    chk("max_done_seen", 32'(seen_done), 1);
    chk("max_busy_cycles", nbusy, 255);
`ifdef TASK_FSM_JOB_CNT_EN
    chk("max_jobcnt", jc0, 1);
`endif
    tick;
    chk("max_idle", state0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
